// File: rtl/room_pkg.sv
// Shared encodings for the room thermal model: mode codes and default bus width.
package room_pkg;

  localparam int TEMP_W_DEF = 5;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_HEAT  = 2'd1,
    MODE_COOL  = 2'd2,
    MODE_FAULT = 2'd3
  } mode_t;

endpackage

// File: rtl/room_temp_model_tick_gen.sv
// Step prescaler: counts advancing clocks and strobes on the last count of each period.
module tick_gen #(
  parameter int STEP_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  output logic step
);

  localparam int CW = (STEP_PERIOD > 2) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_PERIOD - 1);

  logic [CW-1:0] count;

  assign step = advance && (count == LAST);

  // Prescaler counter; holds whenever the model is not advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (advance) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/room_temp_model.sv
// Cycle-based room thermal model: integrates heater/cooler commands into a saturating
// temperature and drifts toward ambient when idle; sticky fault on conflicting commands.
module room_temp_model
  import room_pkg::*;
#(
  parameter int TEMP_W      = TEMP_W_DEF,
  parameter int RESET_TEMP  = 20,
  parameter int AMBIENT     = 15,
  parameter int T_MIN       = 0,
  parameter int T_MAX       = 31,
  parameter int STEP_PERIOD = 4,
  parameter int DRIFT_STEPS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              heating,
  input  logic              cooling,
  output logic [TEMP_W-1:0] temperature,
  output logic [1:0]        mode,
  output logic              tick,
  output logic              fault
);

  localparam int DW = $clog2(DRIFT_STEPS + 1);
  localparam logic [DW-1:0]   DRIFT_LAST = DW'(DRIFT_STEPS - 1);
  localparam logic [TEMP_W:0] MAX_X      = (TEMP_W + 1)'(T_MAX);
  localparam logic [TEMP_W:0] MIN_X      = (TEMP_W + 1)'(T_MIN);
  localparam logic [TEMP_W:0] AMB_X      = (TEMP_W + 1)'(AMBIENT);

  mode_t           mode_q;
  mode_t           next_mode;
  logic [DW-1:0]   drift;
  logic [DW-1:0]   next_drift;
  logic [TEMP_W:0] temp_ext;
  logic [TEMP_W:0] temp_inc;
  logic [TEMP_W:0] temp_dec;
  logic [TEMP_W:0] next_temp;
  logic            freeze;
  logic            step;

  // A conflict seen on this very edge freezes the model immediately, not one cycle late.
  assign freeze = fault | (heating & cooling);
  assign mode   = mode_q;

  tick_gen #(.STEP_PERIOD(STEP_PERIOD)) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .advance (enable & ~freeze),
    .step    (step)
  );

  // Saturating neighbours of the current temperature and the step decision.
  always_comb begin
    temp_ext   = {1'b0, temperature};
    temp_inc   = (temp_ext >= MAX_X) ? MAX_X : temp_ext + (TEMP_W + 1)'(1);
    temp_dec   = (temp_ext <= MIN_X) ? MIN_X : temp_ext - (TEMP_W + 1)'(1);
    next_temp  = temp_ext;
    next_drift = drift;
    next_mode  = MODE_IDLE;
    if (heating) begin
      next_mode  = MODE_HEAT;
      next_temp  = temp_inc;
      next_drift = '0;
    end else if (cooling) begin
      next_mode  = MODE_COOL;
      next_temp  = temp_dec;
      next_drift = '0;
    end else if (drift == DRIFT_LAST) begin
      next_drift = '0;
      if (temp_ext > AMB_X) begin
        next_temp = temp_dec;
      end else if (temp_ext < AMB_X) begin
        next_temp = temp_inc;
      end else begin
        next_temp = temp_ext;
      end
    end else begin
      next_drift = drift + DW'(1);
    end
  end

  // Mode FSM, drift counter and temperature register, all updated only on step edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      temperature <= TEMP_W'(RESET_TEMP);
      mode_q      <= MODE_IDLE;
      tick        <= 1'b0;
      fault       <= 1'b0;
      drift       <= '0;
    end else if (freeze) begin
      fault  <= 1'b1;
      mode_q <= MODE_FAULT;
      tick   <= 1'b0;
    end else if (step) begin
      temperature <= next_temp[TEMP_W-1:0];
      mode_q      <= next_mode;
      drift       <= next_drift;
      tick        <= 1'b1;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_room_temp_model.sv
// Scoreboard bench for room_temp_model: directed stimulus pushes hand-computed step results,
// a negedge monitor pops and compares them whenever tick is seen.
module tb_room_temp_model;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       heating;
  logic       cooling;
  logic [4:0] temperature;
  logic [1:0] mode;
  logic       tick;
  logic       fault;

  typedef struct {
    int t;
    int m;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  room_temp_model dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .heating     (heating),
    .cooling     (cooling),
    .temperature (temperature),
    .mode        (mode),
    .tick        (tick),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every tick must match the oldest queued expectation.
  always @(negedge clk) begin
    if (tick === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_tick got temp=%0d mode=%0d want no tick", temperature, mode);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (temperature !== 5'(e.t) || mode !== 2'(e.m)) begin
          failures++;
          $display("FAIL step_value got temp=%0d mode=%0d want temp=%0d mode=%0d",
                   temperature, mode, e.t, e.m);
        end
      end
    end
  end

  task automatic push(input int t, input int m);
    exp_t e;
    e.t = t;
    e.m = m;
    q.push_back(e);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_temp"}, int'(temperature), 20);
    chk({name, "_mode"}, int'(mode), 0);
    chk({name, "_tick"}, int'(tick), 0);
    chk({name, "_fault"}, int'(fault), 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; heating = 1'b0; cooling = 1'b0;
    run(2);
    chk_reset("reset");

    // Heating from 20: one step every 4 clocks.
    rst = 1'b0; enable = 1'b1; heating = 1'b1;
    for (int v = 21; v <= 25; v++) push(v, 1);
    run(20);
    chk("heat_drained", q.size(), 0);

    // Upper saturation: 26..31 then held at 31.
    for (int v = 26; v <= 31; v++) push(v, 1);
    for (int i = 0; i < 3; i++) push(31, 1);
    run(36);
    chk("sat_high_drained", q.size(), 0);
    chk("sat_high_temp", int'(temperature), 31);

    // Cool down to 17.
    heating = 1'b0; cooling = 1'b1;
    for (int v = 30; v >= 17; v--) push(v, 2);
    run(56);
    chk("cool_drained", q.size(), 0);

    // Idle drift: one degree per 3 steps, stops at ambient 15.
    cooling = 1'b0;
    push(17, 0); push(17, 0); push(16, 0);
    push(16, 0); push(16, 0); push(15, 0);
    for (int i = 0; i < 3; i++) push(15, 0);
    run(36);
    chk("drift_drained", q.size(), 0);
    chk("drift_temp", int'(temperature), 15);

    // Disable at prescaler=2: no ticks, resumes 2 clocks after re-enable.
    run(2);
    enable = 1'b0;
    run(10);
    chk("disable_temp", int'(temperature), 15);
    chk("disable_tick", int'(tick), 0);
    enable = 1'b1;
    push(15, 0);
    run(1);
    chk("reenable_pending", q.size(), 1);
    run(1);
    chk("reenable_drained", q.size(), 0);

    // Fault: conflicting commands for one clock, then heating keeps pushing.
    heating = 1'b1; cooling = 1'b1;
    run(1);
    cooling = 1'b0;
    chk("fault_flag", int'(fault), 1);
    chk("fault_mode", int'(mode), 3);
    run(40);
    chk("fault_frozen_temp", int'(temperature), 15);
    chk("fault_sticky", int'(fault), 1);
    chk("fault_mode_held", int'(mode), 3);
    rst = 1'b1;
    run(1);
    chk_reset("fault_clear");
    rst = 1'b0;

    // Reset mid-run at 24, then first tick 4 clocks after release.
    for (int v = 21; v <= 24; v++) push(v, 1);
    run(16);
    chk("pre_rst_temp", int'(temperature), 24);
    run(2);
    rst = 1'b1;
    run(1);
    chk_reset("mid_rst");
    rst = 1'b0;
    push(21, 1);
    run(3);
    chk("post_rst_pending", q.size(), 1);
    run(1);
    chk("post_rst_drained", q.size(), 0);

    // Lower saturation from 21, then idle drift upward from 0.
    heating = 1'b0; cooling = 1'b1;
    for (int v = 20; v >= 0; v--) push(v, 2);
    push(0, 2); push(0, 2);
    run(92);
    chk("sat_low_temp", int'(temperature), 0);
    cooling = 1'b0;
    push(0, 0); push(0, 0); push(1, 0);
    run(12);
    chk("drift_up_temp", int'(temperature), 1);
    chk("final_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
